// File: rtl/alarme_ctrl.sv
// Sequential alarm controller: exit/entry delays, siren blink,
// 7-seg state digit and saturating trigger counter.
module alarme_ctrl #(
  parameter int EXIT_CYC  = 4,
  parameter int ENTRY_CYC = 3,
  parameter int SIREN_CYC = 8,
  parameter int BLINK_CYC = 2
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic       porta,
  input  logic       relogio,
  input  logic       interruptor,
  output logic       sirene,
  output logic       led_armado,
  output logic [2:0] estado,
  output logic [7:0] seg,
  output logic [3:0] disparos
);

  localparam int M1 = (EXIT_CYC > ENTRY_CYC) ? EXIT_CYC : ENTRY_CYC;
  localparam int M2 = (SIREN_CYC > BLINK_CYC) ? SIREN_CYC : BLINK_CYC;
  localparam int MX = (M1 > M2) ? M1 : M2;
  localparam int TW = $clog2(MX) + 1;

  typedef enum logic [2:0] {
    S_DES = 3'd0,
    S_SAI = 3'd1,
    S_ARM = 3'd2,
    S_ENT = 3'd3,
    S_DIS = 3'd4
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tmr;
  logic [TW-1:0] r_blk;
  logic          r_sir;
  logic [3:0]    r_disp;

  logic r_porta_m, r_porta_s;
  logic r_rel_m, r_rel_s;
  logic r_int_m, r_int_s;
  logic w_arm;

  assign w_arm = r_rel_s & ~r_int_s;

  // Two-flop synchronisers for the raw switch levels.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_porta_m <= 1'b0;
      r_porta_s <= 1'b0;
      r_rel_m   <= 1'b0;
      r_rel_s   <= 1'b0;
      r_int_m   <= 1'b0;
      r_int_s   <= 1'b0;
    end else begin
      r_porta_m <= porta;
      r_porta_s <= r_porta_m;
      r_rel_m   <= relogio;
      r_rel_s   <= r_rel_m;
      r_int_m   <= interruptor;
      r_int_s   <= r_int_m;
    end
  end

  // State sequencing, shared timer, siren blink and trigger count.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_DES;
      r_tmr   <= '0;
      r_blk   <= '0;
      r_sir   <= 1'b0;
      r_disp  <= '0;
    end else begin
      r_sir <= 1'b0;
      r_blk <= '0;
      if (r_state != S_DES && !w_arm) begin
        r_state <= S_DES;
        r_tmr   <= '0;
      end else begin
        unique case (r_state)
          S_DES: begin
            if (w_arm) begin
              r_state <= S_SAI;
              r_tmr   <= '0;
            end
          end
          S_SAI: begin
            if (r_tmr == TW'(EXIT_CYC - 1)) begin
              r_state <= r_porta_s ? S_ENT : S_ARM;
              r_tmr   <= '0;
            end else begin
              r_tmr <= r_tmr + TW'(1);
            end
          end
          S_ARM: begin
            if (r_porta_s) begin
              r_state <= S_ENT;
              r_tmr   <= '0;
            end
          end
          S_ENT: begin
            if (r_tmr == TW'(ENTRY_CYC - 1)) begin
              r_state <= S_DIS;
              r_tmr   <= '0;
              r_sir   <= 1'b1;
              if (r_disp != 4'hF)
                r_disp <= r_disp + 4'd1;
            end else begin
              r_tmr <= r_tmr + TW'(1);
            end
          end
          S_DIS: begin
            if (r_tmr == TW'(SIREN_CYC - 1)) begin
              r_state <= S_ARM;
              r_tmr   <= '0;
            end else begin
              r_tmr <= r_tmr + TW'(1);
              if (r_blk == TW'(BLINK_CYC - 1)) begin
                r_sir <= ~r_sir;
              end else begin
                r_sir <= r_sir;
                r_blk <= r_blk + TW'(1);
              end
            end
          end
          default: begin
            r_state <= S_DES;
            r_tmr   <= '0;
          end
        endcase
      end
    end
  end

  // Direct decode of the state register to LED and 7-seg outputs.
  always_comb begin
    seg[6:0] = 7'h3F;
    unique case (r_state)
      S_SAI:   seg[6:0] = 7'h06;
      S_ARM:   seg[6:0] = 7'h5B;
      S_ENT:   seg[6:0] = 7'h4F;
      S_DIS:   seg[6:0] = 7'h66;
      default: seg[6:0] = 7'h3F;
    endcase
    seg[7] = r_sir;
  end

  assign estado     = r_state;
  assign led_armado = (r_state == S_ARM) || (r_state == S_ENT);
  assign sirene     = r_sir;
  assign disparos   = r_disp;

endmodule

// File: tb/tb_alarme_ctrl.sv
// Scoreboard bench for alarme_ctrl: expected per-cycle outputs
// are queued with the stimulus and popped one per clock.
module tb_alarme_ctrl;

  logic       clk_2;
  logic       reset_n;
  logic       porta;
  logic       relogio;
  logic       interruptor;
  logic       sirene;
  logic       led_armado;
  logic [2:0] estado;
  logic [7:0] seg;
  logic [3:0] disparos;

  int checks;
  int errors;

  typedef struct {
    logic [2:0] st;
    logic       sir;
    logic [3:0] dsp;
  } exp_t;

  exp_t q[$];

  alarme_ctrl #(
    .EXIT_CYC (4),
    .ENTRY_CYC(3),
    .SIREN_CYC(8),
    .BLINK_CYC(2)
  ) dut (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .porta      (porta),
    .relogio    (relogio),
    .interruptor(interruptor),
    .sirene     (sirene),
    .led_armado (led_armado),
    .estado     (estado),
    .seg        (seg),
    .disparos   (disparos)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [2:0] st);
    case (st)
      3'd0:    return 7'h3F;
      3'd1:    return 7'h06;
      3'd2:    return 7'h5B;
      3'd3:    return 7'h4F;
      3'd4:    return 7'h66;
      default: return 7'h00;
    endcase
  endfunction

  task automatic push(input logic [2:0] st, input logic sir,
                      input logic [3:0] dsp, input int n);
    exp_t e;
    e.st  = st;
    e.sir = sir;
    e.dsp = dsp;
    repeat (n) q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      @(posedge clk_2);
      #1;
      e = q.pop_front();
      chk($sformatf("estado@%0t", $time), {5'd0, estado}, {5'd0, e.st});
      chk("sirene", {7'd0, sirene}, {7'd0, e.sir});
      chk("seg", seg, {e.sir, seg_of(e.st)});
      chk("led_armado", {7'd0, led_armado},
          {7'd0, (e.st == 3'd2) || (e.st == 3'd3)});
      chk("disparos", {4'd0, disparos}, {4'd0, e.dsp});
    end
  endtask

  // Remaining entry delay, full siren, one ARMADO cycle, re-entry.
  task automatic trig_loop(input int dprev);
    logic [3:0] d0;
    logic [3:0] d1;
    d0 = 4'(dprev);
    d1 = (dprev >= 15) ? 4'd15 : 4'(dprev + 1);
    push(3'd3, 1'b0, d0, 2);
    for (int i = 0; i < 8; i++)
      push(3'd4, ((i / 2) % 2) == 0, d1, 1);
    push(3'd2, 1'b0, d1, 1);
    push(3'd3, 1'b0, d1, 1);
    drain();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    porta       = 1'b0;
    relogio     = 1'b0;
    interruptor = 1'b0;
    #12;
    chk("rst_estado", {5'd0, estado}, 8'd0);
    chk("rst_seg", seg, 8'h3F);
    chk("rst_sirene", {7'd0, sirene}, 8'd0);
    chk("rst_disparos", {4'd0, disparos}, 8'd0);
    @(negedge clk_2);
    reset_n = 1'b1;

    // Disarmed idle
    push(3'd0, 1'b0, 4'd0, 10);
    drain();

    // Exit delay then armed
    relogio = 1'b1;
    push(3'd0, 1'b0, 4'd0, 2);
    push(3'd1, 1'b0, 4'd0, 4);
    push(3'd2, 1'b0, 4'd0, 2);
    drain();

    // Door opens: entry, siren, back to armed, re-entry
    porta = 1'b1;
    push(3'd2, 1'b0, 4'd0, 2);
    push(3'd3, 1'b0, 4'd0, 1);
    drain();
    trig_loop(0);

    // Disarm lands on the entry expiry edge
    interruptor = 1'b1;
    push(3'd3, 1'b0, 4'd1, 2);
    push(3'd0, 1'b0, 4'd1, 3);
    drain();

    // Door open through the exit delay goes straight to entry
    interruptor = 1'b0;
    push(3'd0, 1'b0, 4'd1, 2);
    push(3'd1, 1'b0, 4'd1, 4);
    push(3'd3, 1'b0, 4'd1, 1);
    drain();
    trig_loop(1);

    // Keep triggering past saturation
    for (int d = 2; d <= 16; d++)
      trig_loop(d > 15 ? 15 : d);

    // Async reset while the siren is on
    push(3'd3, 1'b0, 4'd15, 2);
    push(3'd4, 1'b1, 4'd15, 2);
    drain();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_sirene", {7'd0, sirene}, 8'd0);
    chk("arst_estado", {5'd0, estado}, 8'd0);
    chk("arst_disparos", {4'd0, disparos}, 8'd0);
    chk("arst_seg", seg, 8'h3F);
    #1;
    reset_n = 1'b1;
    push(3'd0, 1'b0, 4'd0, 2);
    push(3'd1, 1'b0, 4'd0, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarme_ctrl.md
Name: alarme_ctrl

Overview:
- Sequential alarm controller downstream of the board's combinational alarm logic.
- Takes the raw door, clock and override switch levels and synchronises them.
- Sequences them through exit delay, armed, entry delay and triggered states.
- Drives a blinking siren LED, a 7-segment state digit and a trigger counter to the top-level LED/SEG pins.

Parameters:
EXIT_CYC, 4, exit-delay length in clk_2 cycles (>=1)
ENTRY_CYC, 3, entry-delay length in clk_2 cycles (>=1)
SIREN_CYC, 8, siren duration in clk_2 cycles (>=1)
BLINK_CYC, 2, siren half-period in clk_2 cycles (>=1)

Ports:
clk_2  input  1  board clock
reset_n  input  1  asynchronous, active-low reset
porta  input  1  door switch, 1 = open (async, from SWI)
relogio  input  1  night window, 1 = alarm period (async, from SWI)
interruptor  input  1  override, 1 = user disables alarm (async, from SWI)
sirene  output  1  siren LED
led_armado  output  1  1 in ARMADO or ENTRADA
estado  output  3  current state code
seg  output  8  7-seg pattern, bits[6:0]=gfedcba active-high, bit7=sirene
disparos  output  4  saturating count of entries into DISPARADO

Behaviour:
- Clock and reset:
  - One clock, clk_2.
  - reset_n is asynchronous, active-low.
  - While low, all flops clear: state DESARMADO, sync flops 0, counters 0, sirene 0, led_armado 0, estado 0, seg 8'h3F, disparos 0.
  - Release takes effect on the next clk_2 edge.
- Input synchronisation:
  - Each input passes through a 2-flop synchroniser. Internal porta_s, relogio_s, interruptor_s lag the pins by 2 cycles.
  - arm_req = relogio_s & ~interruptor_s.
- States and estado codes: DESARMADO=0, SAIDA=1, ARMADO=2, ENTRADA=3, DISPARADO=4.
- Transitions (registered, evaluated each edge, listed in priority order):
  - Any state except DESARMADO with arm_req=0 -> DESARMADO. Disarm overrides every timer expiry.
  - DESARMADO: arm_req=1 -> SAIDA, tmr<=0.
  - SAIDA: tmr increments each cycle. At tmr==EXIT_CYC-1: -> ENTRADA if porta_s=1, else -> ARMADO. SAIDA lasts exactly EXIT_CYC cycles.
  - ARMADO: porta_s=1 -> ENTRADA, tmr<=0.
  - ENTRADA: tmr increments. At tmr==ENTRY_CYC-1 -> DISPARADO, tmr<=0. Closing the door does not cancel the entry delay; only disarm does.
  - DISPARADO: tmr increments. At tmr==SIREN_CYC-1 -> ARMADO. If the door is still open, ARMADO moves to ENTRADA on the following edge.
  - Illegal state codes 5..7 -> DESARMADO.
- Timer:
  - A single shared counter, width $clog2 of the largest parameter +1.
  - Cleared on every state change.
- Siren:
  - sirene is registered.
  - On the edge entering DISPARADO, sirene<=1 and blink counter<=0.
  - In DISPARADO, sirene toggles every BLINK_CYC cycles.
  - sirene is 0 in every other state, including the first cycle after leaving DISPARADO.
- Trigger counter: disparos increments on each edge entering DISPARADO and saturates at 15.
- Decoding:
  - estado and led_armado are direct decodes of the state register, with no extra latency.
  - seg[6:0] by state: 0 -> 3F, 1 -> 06, 2 -> 5B, 3 -> 4F, 4 -> 66.
  - seg[7] = sirene.
- Asynchronous reset mid-sequence returns to DESARMADO immediately. No residual siren.

Test Plan:
1. Reset and disarmed input: reset_n=0 then 1; relogio=0 for 10 cycles -> estado=0, seg=8'h3F, sirene=0, disparos=0 throughout.
2. Exit delay: relogio=1, interruptor=0, porta=0 -> estado=1 from the 3rd edge after the input change, for exactly 4 cycles, then estado=2, led_armado=1, seg=8'h5B.
3. Full trigger: from ARMADO raise porta=1 -> estado=3 for 3 cycles, then estado=4 for 8 cycles with sirene 1,1,0,0,1,1,0,0 and seg[7] matching. disparos=1. Then estado=2 for one cycle and estado=3 again, because the door is still open.
4. Disarm overrides: in ENTRADA at tmr=2 (the expiry cycle), raise interruptor so arm_req falls on that edge -> estado=0, never 4, and disparos unchanged.
5. Saturation and async reset: force 16 triggers -> disparos=15 holds. Pulse reset_n low mid-DISPARADO without a clock edge -> sirene=0, estado=0, disparos=0 immediately.
6. Door open at exit expiry: porta=1 throughout SAIDA -> after 4 cycles, estado=3 directly, skipping 2.
